regfile_write_arbiter: RTL

// Shares the single write port of the 32x32 register file between NUM_REQ writeback sources.

---
 rtl/rv_regfile_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv_regfile_pkg.sv
// ============================================================================
// Module : rv_regfile_pkg
// Brief  : Shared register-file geometry and writeback source identifiers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_MUL = 2'd2
  } wb_src_e;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin search starting at a supplied pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_valid = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      // Candidate index wraps modulo N without a divider.
      w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(N)) begin
        w_sum = w_sum - (IDX_W + 1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_gnt_valid && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt_valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module : regfile_write_arbiter
// Brief  : Round-robin sharing of the register-file write port plus a
//          per-register busy scoreboard that stalls issue on WAW hazards.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*XLEN-1:0]       reqData,
  output logic [NUM_REQ-1:0]            reqReady,
  input  logic                          issueValid,
  input  logic [REG_ADDR_W-1:0]         issueAddr,
  output logic                          issueReady,
  output logic [(1<<REG_ADDR_W)-1:0]    busy,
  output logic                          writeEn,
  output logic [REG_ADDR_W-1:0]         writeAddr,
  output logic [XLEN-1:0]               writeData
);

  localparam int c_NUM_REGS = 1 << REG_ADDR_W;
  localparam int c_IDX_W    = $clog2(NUM_REQ);

  logic [c_IDX_W-1:0]    r_rr_ptr;
  logic [c_IDX_W-1:0]    w_gnt_idx;
  logic [c_IDX_W-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_gnt_valid;
  logic [REG_ADDR_W-1:0] w_addr_arr [NUM_REQ];
  logic [XLEN-1:0]       w_data_arr [NUM_REQ];
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_issue_ready;
  logic [c_NUM_REGS-1:0] w_busy_next;
  logic [c_NUM_REGS-1:0] r_busy;
  logic                  r_write_en;
  logic [REG_ADDR_W-1:0] r_write_addr;
  logic [XLEN-1:0]       r_write_data;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = reqAddr[gi*REG_ADDR_W +: REG_ADDR_W];
      assign w_data_arr[gi] = reqData[gi*XLEN +: XLEN];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr_arbiter (
    .i_req       (reqValid),
    .i_ptr       (r_rr_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign reqReady = arstn ? w_gnt : '0;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_addr = w_sel_addr | (w_addr_arr[i] & {REG_ADDR_W{w_gnt[i]}});
      w_sel_data = w_sel_data | (w_data_arr[i] & {XLEN{w_gnt[i]}});
    end
  end

  assign w_ptr_next = (w_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + c_IDX_W'(1);

  // Busy is read from the registered copy, so a same-cycle clear never unblocks issue.
  assign w_issue_ready = !r_busy[issueAddr] || (issueAddr == '0);

  always_comb begin
    w_busy_next = r_busy;
    if (r_write_en) begin
      w_busy_next[r_write_addr] = 1'b0;
    end
    if (issueValid && w_issue_ready && (issueAddr != '0)) begin
      w_busy_next[issueAddr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_rr_ptr     <= '0;
      r_busy       <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_gnt_valid) begin
        r_rr_ptr     <= w_ptr_next;
        r_write_en   <= (w_sel_addr != '0);
        r_write_addr <= w_sel_addr;
        r_write_data <= w_sel_data;
      end else begin
        r_write_en <= 1'b0;
      end
    end
  end

  assign issueReady = w_issue_ready;
  assign busy       = r_busy;
  assign writeEn    = r_write_en;
  assign writeAddr  = r_write_addr;
  assign writeData  = r_write_data;

endmodule

`default_nettype wire
